// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding and the grant encoding used when picking a winner.
package unified_mem_arbiter_pkg;

    // FSM state encoding. Kept as plain 2-bit constants so the encoding
    // stays stable for older tools and any code that decodes the state.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_IF_BUSY = 2'd1;
    localparam state_t ST_DM_BUSY = 2'd2;

    // Grant encoding: which requester won arbitration in IDLE.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// fetch stage (instruction reads) and the MEM stage (loads/stores).
// Accesses are serialised through IDLE -> IF_BUSY/DM_BUSY -> IDLE, and
// combinational stall requests hold each requester until its valid pulse.
module unified_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // Data port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    // Memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    // Pipeline stall requests
    output logic              stall_if,
    output logic              stall_mem
);

    import unified_mem_arbiter_pkg::*;

    state_t            state_q,     state_d;
    logic              fair_q,      fair_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_valid_q,  dm_valid_d;

    logic              gnt_vld;
    logic              gnt_sel;

    // Next-state logic: arbitration in IDLE, completion handling when busy.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        fair_d      = fair_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        gnt_vld     = 1'b0;
        gnt_sel     = GNT_DM;

        case (state_q)
            ST_IDLE: begin
                // Data wins unless fetch is also waiting and data had the
                // previous grant; this stops store bursts starving fetch.
                // A stray mem_ack here is simply not looked at.
                if (dm_req && !(if_req && fair_q)) begin
                    gnt_vld = 1'b1;
                    gnt_sel = GNT_DM;
                end else if (if_req) begin
                    gnt_vld = 1'b1;
                    gnt_sel = GNT_IF;
                end

                if (gnt_vld) begin
                    mem_req_d = 1'b1;
                    if (gnt_sel == GNT_DM) begin
                        state_d     = ST_DM_BUSY;
                        fair_d      = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        state_d    = ST_IF_BUSY;
                        fair_d     = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end

            ST_IF_BUSY: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            ST_DM_BUSY: begin
                if (mem_ack) begin
                    // Stores complete with a valid pulse but keep the last
                    // load result intact.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fair_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            fair_q      <= fair_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;

    // Stalls drop in the valid cycle so the pipeline advances exactly once.
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: requester agents replay job
// queues, a memory model answers with programmable latency, and a
// scoreboard compares every valid pulse against the expected data.
module tb_unified_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_job_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;

    int errors = 0;
    int checks = 0;

    logic [31:0] if_jobs[$];
    dm_job_t     dm_jobs[$];
    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];
    acc_t        acc_log[$];
    logic [31:0] mem [logic [31:0]];

    int   lat = 1;
    int   cnt = 0;
    logic resp_ack = 1'b0;
    logic stray_ack = 1'b0;
    logic [31:0] hold_addr;
    logic        hold_we;
    int   if_vcnt = 0;
    int   dm_vcnt = 0;

    assign mem_ack = resp_ack | stray_ack;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hC0DE_0B05 ^ (a << 4);
    endfunction

    // Fetch agent: holds if_req/if_addr for the head job until its valid.
    always @(posedge clk) begin
        #1;
        if (if_valid && if_req && if_jobs.size() > 0) if_jobs.delete(0);
        if (if_jobs.size() > 0) begin
            if_req  = 1'b1;
            if_addr = if_jobs[0];
        end else begin
            if_req = 1'b0;
        end
    end

    // Data agent: same handshake for loads and stores.
    always @(posedge clk) begin
        #1;
        if (dm_valid && dm_req && dm_jobs.size() > 0) dm_jobs.delete(0);
        if (dm_jobs.size() > 0) begin
            dm_req   = 1'b1;
            dm_we    = dm_jobs[0].we;
            dm_addr  = dm_jobs[0].addr;
            dm_wdata = dm_jobs[0].wdata;
        end else begin
            dm_req = 1'b0;
        end
    end

    // Memory model: acks 'lat' cycles after mem_req first rises and checks
    // the request stays stable while it waits.
    always @(posedge clk) begin
        acc_t a;
        #1;
        resp_ack = 1'b0;
        if (!mem_req) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == 1) begin
                hold_addr = mem_addr;
                hold_we   = mem_we;
            end else begin
                check("req_addr_stable", mem_addr, hold_addr);
                check("req_we_stable", 32'(mem_we), 32'(hold_we));
            end
            if (cnt == lat + 1) begin
                resp_ack = 1'b1;
                a.we   = mem_we;
                a.addr = mem_addr;
                acc_log.push_back(a);
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem[mem_addr];
            end
        end
    end

    // Scoreboard: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (if_valid) begin
            if_vcnt++;
            if (if_exp.size() == 0) check("if_valid_unexpected", 32'(if_valid), 32'd0);
            else begin
                check("if_rdata", if_rdata, if_exp[0]);
                if_exp.delete(0);
            end
        end
        if (dm_valid) begin
            dm_vcnt++;
            if (dm_exp.size() == 0) check("dm_valid_unexpected", 32'(dm_valid), 32'd0);
            else begin
                check("dm_rdata", dm_rdata, dm_exp[0]);
                dm_exp.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (i < budget &&
               (if_jobs.size() + dm_jobs.size() + if_exp.size() + dm_exp.size()) != 0) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(if_jobs.size() + dm_jobs.size() + if_exp.size() + dm_exp.size()), 32'd0);
        cycles(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),  32'd0);
        check({tag, "_mem_we"},    32'(mem_we),   32'd0);
        check({tag, "_mem_addr"},  mem_addr,      32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,     32'd0);
        check({tag, "_if_rdata"},  if_rdata,      32'd0);
        check({tag, "_dm_rdata"},  dm_rdata,      32'd0);
        check({tag, "_if_valid"},  32'(if_valid), 32'd0);
        check({tag, "_dm_valid"},  32'(dm_valid), 32'd0);
    endtask

    // Single fetch from IDLE with 1-cycle memory latency: mem_req in
    // cycles 1-2, valid in cycle 3, stall_if in cycles 0-2.
    task automatic lone_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        lat = 1;
        if_jobs.push_back(addr);
        if_exp.push_back(data);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check({tag, "_mem_req"},  32'(mem_req),  32'((c == 1) || (c == 2)));
            check({tag, "_if_valid"}, 32'(if_valid), 32'(c == 3));
            check({tag, "_stall_if"}, 32'(stall_if), 32'(c <= 2));
            if (c == 1) check({tag, "_mem_addr"}, mem_addr, addr);
            if (c == 3) check({tag, "_if_rdata"}, if_rdata, data);
        end
        wait_drain({tag, "_drain"}, 20);
    endtask

    initial begin
        logic [31:0] addrs [10];
        logic [31:0] last_ld;
        dm_job_t     j;
        int          dm_at;
        int          if_at;
        int          req_cyc;
        int          v0;
        int          w0;
        logic        seen;
        logic [31:0] st_addr  [3];
        logic [31:0] st_data  [3];
        logic [31:0] ord_addr [6];
        logic        ord_we   [6];

        addrs = '{32'h20, 32'h40, 32'h44, 32'h48, 32'h50,
                  32'h100, 32'h104, 32'h200, 32'h204, 32'h60};
        foreach (addrs[k]) mem[addrs[k]] = init_word(addrs[k]);
        mem[32'h10] = 32'h0050_0093;

        // Reset values
        cycles(2);
        check_reset_outputs("rst");
        check("rst_stall_if", 32'(stall_if), 32'd0);
        check("rst_stall_mem", 32'(stall_mem), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Lone fetch
        lone_fetch("fetch", 32'h10, 32'h0050_0093);

        // Load and fetch collide in IDLE: data first, fetch stalls throughout
        acc_log.delete();
        last_ld = init_word(32'h100);
        j.we = 1'b0; j.addr = 32'h100; j.wdata = 32'h0;
        dm_jobs.push_back(j);
        dm_exp.push_back(last_ld);
        if_jobs.push_back(32'h20);
        if_exp.push_back(init_word(32'h20));
        dm_at = -1;
        if_at = -1;
        for (int c = 0; c < 40 && if_at < 0; c++) begin
            @(negedge clk);
            if (dm_valid && dm_at < 0) dm_at = c;
            if (dm_at < 0) check("coll_stall_mem", 32'(stall_mem), 32'd1);
            if (if_valid) if_at = c;
            else          check("coll_stall_if", 32'(stall_if), 32'd1);
        end
        check("coll_dm_valid_cycle", 32'(dm_at), 32'd3);
        check("coll_if_valid_cycle", 32'(if_at), 32'd6);
        wait_drain("coll_drain", 20);
        check("coll_access_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            check("coll_first_addr", acc_log[0].addr, 32'h100);
            check("coll_second_addr", acc_log[1].addr, 32'h20);
        end

        // Three back-to-back stores with fetch pending: accesses alternate
        acc_log.delete();
        st_addr = '{32'h300, 32'h304, 32'h308};
        st_data = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003};
        for (int k = 0; k < 3; k++) begin
            j.we = 1'b1; j.addr = st_addr[k]; j.wdata = st_data[k];
            dm_jobs.push_back(j);
            dm_exp.push_back(last_ld);
        end
        if_jobs.push_back(32'h40); if_exp.push_back(init_word(32'h40));
        if_jobs.push_back(32'h44); if_exp.push_back(init_word(32'h44));
        if_jobs.push_back(32'h48); if_exp.push_back(init_word(32'h48));
        wait_drain("fair_drain", 100);
        ord_addr = '{32'h300, 32'h40, 32'h304, 32'h44, 32'h308, 32'h48};
        ord_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        check("fair_access_count", 32'(acc_log.size()), 32'd6);
        if (acc_log.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("fair_order_addr%0d", k), acc_log[k].addr, ord_addr[k]);
                check($sformatf("fair_order_we%0d", k), 32'(acc_log[k].we), 32'(ord_we[k]));
            end
        end
        for (int k = 0; k < 3; k++) check($sformatf("fair_stored%0d", k), mem[st_addr[k]], st_data[k]);
        check("fair_dm_rdata_kept", dm_rdata, last_ld);

        // Five-cycle memory latency: one valid, request held stable
        lat = 5;
        v0 = dm_vcnt;
        req_cyc = 0;
        last_ld = init_word(32'h200);
        j.we = 1'b0; j.addr = 32'h200; j.wdata = 32'h0;
        dm_jobs.push_back(j);
        dm_exp.push_back(last_ld);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req) req_cyc++;
        end
        check("lat5_req_cycles", 32'(req_cyc), 32'd6);
        check("lat5_valid_pulses", 32'(dm_vcnt - v0), 32'd1);
        wait_drain("lat5_drain", 10);

        // Reset while a load waits on memory
        lat = 20;
        j.we = 1'b0; j.addr = 32'h204; j.wdata = 32'h0;
        dm_jobs.push_back(j);
        dm_exp.push_back(init_word(32'h204));
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_req;
        end
        check("rstmid_req_seen", 32'(seen), 32'd1);
        cycles(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        dm_jobs.delete();
        dm_exp.delete();
        cycles(2);
        rst_n = 1'b1;
        v0 = dm_vcnt;
        w0 = if_vcnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rstmid_no_req", 32'(mem_req), 32'd0);
        end
        check("rstmid_no_dm_valid", 32'(dm_vcnt - v0), 32'd0);
        check("rstmid_no_if_valid", 32'(if_vcnt - w0), 32'd0);

        // Stray ack in IDLE: ignored, next fetch has normal timing
        @(posedge clk); #2; stray_ack = 1'b1;
        @(posedge clk); #2; stray_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stray_if_valid", 32'(if_valid), 32'd0);
            check("stray_dm_valid", 32'(dm_valid), 32'd0);
            check("stray_mem_req", 32'(mem_req), 32'd0);
        end
        lone_fetch("post_stray", 32'h50, init_word(32'h50));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
